// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer for the green LED bank.
// A free-running step counter paces four patterns (OFF, BLINK, ALTERNATE,
// CHASE) at four rates. Mode/rate requests are captured on a load strobe and
// held as pending until the next pattern step, so a pattern never changes
// mid-period. LEDG is decoded purely from registered state.
module led_pattern_ctrl #(
    parameter int N_LEDS   = 8,
    parameter int BASE_DIV = 50000000
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic [1:0]        mode_in,
    input  logic [1:0]        rate_in,
    input  logic              mode_load,
    output logic [N_LEDS-1:0] LEDG,
    output logic              tick,
    output logic              pending
);

    localparam int CW = $clog2(BASE_DIV + 1);
    localparam logic [N_LEDS-1:0] POS_INIT = {{(N_LEDS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_ALT   = 2'd2,
        MODE_CHASE = 2'd3
    } mode_t;

    logic [CW-1:0]     count_reg,     count_next;
    logic [1:0]        rate_reg,      rate_next;
    mode_t             mode_reg,      mode_next;
    logic              state_reg,     state_next;
    logic [N_LEDS-1:0] pos_reg,       pos_next;
    logic              pend_reg,      pend_next;
    logic [1:0]        pend_mode_reg, pend_mode_next;
    logic [1:0]        pend_rate_reg, pend_rate_next;
    logic              tick_reg,      tick_next;

    logic [CW-1:0]     limit;
    logic              step;

    // Step period shrinks by a factor of two per rate level.
    assign limit = CW'(BASE_DIV >> rate_reg);
    assign step  = (count_reg == (limit - CW'(1)));

    // Register bank; everything clears as soon as rst_n falls.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            rate_reg      <= 2'd0;
            mode_reg      <= MODE_OFF;
            state_reg     <= 1'b0;
            pos_reg       <= POS_INIT;
            pend_reg      <= 1'b0;
            pend_mode_reg <= 2'd0;
            pend_rate_reg <= 2'd0;
            tick_reg      <= 1'b0;
        end else begin
            count_reg     <= count_next;
            rate_reg      <= rate_next;
            mode_reg      <= mode_next;
            state_reg     <= state_next;
            pos_reg       <= pos_next;
            pend_reg      <= pend_next;
            pend_mode_reg <= pend_mode_next;
            pend_rate_reg <= pend_rate_next;
            tick_reg      <= tick_next;
        end
    end

    // Next-state: counter wrap, pattern advance or pending apply, request capture.
    always_comb begin
        count_next     = count_reg + CW'(1);
        rate_next      = rate_reg;
        mode_next      = mode_reg;
        state_next     = state_reg;
        pos_next       = pos_reg;
        pend_next      = pend_reg;
        pend_mode_next = pend_mode_reg;
        pend_rate_next = pend_rate_reg;
        tick_next      = step;

        if (step) begin
            count_next = '0;
            if (pend_reg) begin
                // Applying restarts phase and position even if the request
                // matches what is already running.
                mode_next  = mode_t'(pend_mode_reg);
                rate_next  = pend_rate_reg;
                state_next = 1'b0;
                pos_next   = POS_INIT;
                pend_next  = 1'b0;
            end else begin
                state_next = ~state_reg;
                pos_next   = {pos_reg[N_LEDS-2:0], pos_reg[N_LEDS-1]};
            end
        end

        // A load coinciding with a step is kept for the following step,
        // since the apply above uses the previously captured request.
        if (mode_load) begin
            pend_next      = 1'b1;
            pend_mode_next = mode_in;
            pend_rate_next = rate_in;
        end
    end

    assign tick    = tick_reg;
    assign pending = pend_reg;

    // Per-bit pattern decode from registered mode, phase and chase position.
    generate
        for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
            localparam bit EVEN_BIT = ((gi % 2) == 0);
            logic alt_bit;
            assign alt_bit  = EVEN_BIT ? state_reg : ~state_reg;
            assign LEDG[gi] = (mode_reg == MODE_CHASE) ? pos_reg[gi] :
                              (mode_reg == MODE_BLINK) ? state_reg   :
                              (mode_reg == MODE_ALT)   ? alt_bit     :
                                                         1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus random loads, every
// cycle compared against a step-count reference model.
module tb_led_pattern_ctrl;

    localparam int N  = 8;
    localparam int BD = 8;

    logic         clk_50 = 1'b0;
    logic         rst_n;
    logic [1:0]   mode_in;
    logic [1:0]   rate_in;
    logic         mode_load;
    logic [N-1:0] LEDG;
    logic         tick;
    logic         pending;

    int n_checks = 0;
    int n_fail   = 0;

    led_pattern_ctrl #(.N_LEDS(N), .BASE_DIV(BD)) dut (
        .clk_50   (clk_50),
        .rst_n    (rst_n),
        .mode_in  (mode_in),
        .rate_in  (rate_in),
        .mode_load(mode_load),
        .LEDG     (LEDG),
        .tick     (tick),
        .pending  (pending)
    );

    always #5 clk_50 = ~clk_50;

    // Reference model: edges elapsed in the current step, pattern phase,
    // chase index and the pending request.
    int m_el, m_mode, m_rate, m_pos, m_pmode, m_prate;
    bit m_phase, m_pend, m_tick;

    function automatic void model_reset();
        m_el = 0; m_mode = 0; m_rate = 0; m_pos = 0;
        m_pmode = 0; m_prate = 0; m_phase = 0; m_pend = 0; m_tick = 0;
    endfunction

    function automatic void model_edge(bit load, int md, int rt);
        int period;
        period = BD >> m_rate;
        m_el++;
        m_tick = 0;
        if (m_el == period) begin
            m_el   = 0;
            m_tick = 1;
            if (m_pend) begin
                m_mode  = m_pmode;
                m_rate  = m_prate;
                m_phase = 0;
                m_pos   = 0;
                m_pend  = 0;
            end else begin
                m_phase = ~m_phase;
                m_pos   = (m_pos + 1) % N;
            end
        end
        if (load) begin
            m_pmode = md;
            m_prate = rt;
            m_pend  = 1;
        end
    endfunction

    function automatic bit next_is_step();
        return (m_el + 1) == (BD >> m_rate);
    endfunction

    function automatic logic [N-1:0] exp_leds();
        logic [N-1:0] v;
        v = '0;
        case (m_mode)
            1: v = m_phase ? {N{1'b1}} : {N{1'b0}};
            2: for (int i = 0; i < N; i++) v[i] = ((i % 2) == 0) ? m_phase : ~m_phase;
            3: v[m_pos] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".LEDG"},    32'(LEDG),    32'(exp_leds()));
        check({tag, ".tick"},    32'(tick),    32'(m_tick));
        check({tag, ".pending"}, 32'(pending), 32'(m_pend));
        $display("[%0t] %s load=%0b LEDG=%02h tick=%0b pending=%0b", $time, tag,
                 mode_load, LEDG, tick, pending);
    endtask

    // One clock with optional load; inputs change 1 time unit after the edge.
    task automatic cyc(input string tag, input bit load, input int md, input int rt);
        mode_load = load;
        mode_in   = 2'(md);
        rate_in   = 2'(rt);
        @(posedge clk_50);
        model_edge(load, md, rt);
        #1;
        mode_load = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 0, 0);
    endtask

    task automatic wait_step_edge(input string tag);
        int guard;
        guard = 0;
        while (!next_is_step() && guard < 64) begin
            cyc(tag, 1'b0, 0, 0);
            guard++;
        end
        check({tag, ".step_reached"}, 32'(next_is_step()), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; mode_in = 2'd0; rate_in = 2'd0; mode_load = 1'b0;
        model_reset();

        // Held in reset: outputs at their reset values.
        repeat (2) @(posedge clk_50);
        #1;
        check("reset.LEDG",    32'(LEDG),    32'h0);
        check("reset.tick",    32'(tick),    32'h0);
        check("reset.pending", 32'(pending), 32'h0);
        @(negedge clk_50);
        rst_n = 1'b1;

        // 1: no loads, OFF, ticks every 8 edges.
        idle("s1", 26);

        // 2: ALTERNATE at rate 0.
        cyc("s2", 1'b1, 2, 0);
        idle("s2", 24);

        // 3: CHASE at rate 3 (one step per cycle).
        cyc("s3", 1'b1, 3, 3);
        idle("s3", 20);

        // 4: back to BLINK at rate 1 while stepping every cycle.
        cyc("s4", 1'b1, 1, 1);
        idle("s4", 16);

        // 5a: load exactly on a step edge; applied one step later.
        wait_step_edge("s5a");
        cyc("s5a.load_on_step", 1'b1, 2, 0);
        check("s5a.still_pending", 32'(pending), 32'd1);
        idle("s5a", 20);

        // 5b: two loads before one step; the last wins.
        cyc("s5b.load1", 1'b1, 1, 2);
        cyc("s5b.load2", 1'b1, 2, 2);
        idle("s5b", 12);

        // Same mode/rate again still restarts the phase at apply.
        cyc("s5c.reload", 1'b1, 2, 2);
        idle("s5c", 10);

        // Random loads at random intervals.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0)
                cyc("rnd", 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                cyc("rnd", 1'b0, 0, 0);
        end

        // 6: CHASE, then asynchronous reset between edges.
        cyc("s6", 1'b1, 3, 0);
        idle("s6", 20);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("s6.async.LEDG",    32'(LEDG),    32'h0);
        check("s6.async.tick",    32'(tick),    32'h0);
        check("s6.async.pending", 32'(pending), 32'h0);
        @(posedge clk_50);
        #1;
        check("s6.held.LEDG", 32'(LEDG), 32'h0);
        @(negedge clk_50);
        rst_n = 1'b1;
        idle("s6.after", 26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
